// File: rtl/calc_key_entry.sv
`timescale 1ns/1ps
// calc_key_entry: turns a key-code stream into packed BCD operands and an
// opcode for the ALU, then waits a fixed latency and captures the result.
module calc_key_entry #(
   parameter int ALU_LAT = 2
) (
   input  logic        clk,
   input  logic        clear,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic        key_ready,
   input  logic [15:0] alu_result,
   input  logic        alu_special,
   output logic [15:0] bcd1,
   output logic [15:0] bcd2,
   output logic [1:0]  op_selected,
   output logic [15:0] display,
   output logic        display_neg,
   output logic        result_valid
);

   localparam int WAIT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ALU_LAT - 1);

   typedef enum logic [1:0] {S_OP1, S_OP2, S_CALC, S_SHOW} state_t;

   state_t            r_state, w_state_nxt;
   logic [15:0]       r_bcd1, w_bcd1_nxt;
   logic [15:0]       r_bcd2, w_bcd2_nxt;
   logic [1:0]        r_op, w_op_nxt;
   logic [15:0]       r_disp, w_disp_nxt;
   logic              r_neg, w_neg_nxt;
   logic              r_rv, w_rv_nxt;
   logic [2:0]        r_cnt, w_cnt_nxt;
   logic [WAIT_W-1:0] r_wait, w_wait_nxt;

   logic              w_accept;
   logic              w_is_digit;
   logic              w_is_op;
   logic              w_is_eq;
   logic              w_is_clr;
   logic [1:0]        w_op_code;

   // Place a digit into the nibble selected by how many digits are already in
   // (MSD first, left-justified). A full operand is returned unchanged.
   function automatic logic [15:0] put_digit(input logic [15:0] v,
                                             input logic [2:0]  n,
                                             input logic [3:0]  d);
      logic [15:0] r;
      r = v;
      case (n)
         3'd0:    r[15:12] = d;
         3'd1:    r[11:8]  = d;
         3'd2:    r[7:4]   = d;
         3'd3:    r[3:0]   = d;
         default: r = v;
      endcase
      return r;
   endfunction

   assign key_ready  = (r_state != S_CALC);
   assign w_accept   = key_valid & key_ready;
   assign w_is_digit = (key_code <= 4'd9);
   assign w_is_op    = (key_code == 4'hA) || (key_code == 4'hB);
   assign w_is_eq    = (key_code == 4'hC);
   assign w_is_clr   = (key_code == 4'hE);
   assign w_op_code  = (key_code == 4'hA) ? 2'b01 : 2'b10;

   // Next-state and next-register values for the entry sequencer.
   always_comb begin
      w_state_nxt = r_state;
      w_bcd1_nxt  = r_bcd1;
      w_bcd2_nxt  = r_bcd2;
      w_op_nxt    = r_op;
      w_disp_nxt  = r_disp;
      w_neg_nxt   = r_neg;
      w_rv_nxt    = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_wait_nxt  = r_wait;

      if (w_accept && w_is_clr) begin
         // E behaves like clear, but on the clock edge
         w_state_nxt = S_OP1;
         w_bcd1_nxt  = '0;
         w_bcd2_nxt  = '0;
         w_op_nxt    = 2'b00;
         w_disp_nxt  = '0;
         w_neg_nxt   = 1'b0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_OP1: begin
               if (w_accept && w_is_digit) begin
                  if (r_cnt < 3'd4) begin
                     w_bcd1_nxt = put_digit(r_bcd1, r_cnt, key_code);
                     w_disp_nxt = w_bcd1_nxt;
                     w_cnt_nxt  = r_cnt + 3'd1;
                  end
               end else if (w_accept && w_is_op && (r_cnt != 3'd0)) begin
                  w_op_nxt    = w_op_code;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_OP2;
               end
            end
            S_OP2: begin
               if (w_accept && w_is_digit) begin
                  if (r_cnt < 3'd4) begin
                     w_bcd2_nxt = put_digit(r_bcd2, r_cnt, key_code);
                     w_disp_nxt = w_bcd2_nxt;
                     w_cnt_nxt  = r_cnt + 3'd1;
                  end
               end else if (w_accept && w_is_op && (r_cnt == 3'd0)) begin
                  // operator re-selected before any operand-2 digit
                  w_op_nxt = w_op_code;
               end else if (w_accept && w_is_eq && (r_cnt != 3'd0)) begin
                  w_wait_nxt  = WAIT_LOAD;
                  w_state_nxt = S_CALC;
               end
            end
            S_CALC: begin
               // operands and opcode are frozen while the ALU settles
               if (r_wait == '0) begin
                  w_disp_nxt  = alu_result;
                  w_neg_nxt   = alu_special;
                  w_rv_nxt    = 1'b1;
                  w_state_nxt = S_SHOW;
               end else begin
                  w_wait_nxt = r_wait - WAIT_W'(1);
               end
            end
            S_SHOW: begin
               if (w_accept && w_is_digit) begin
                  // a digit starts a fresh calculation
                  w_bcd1_nxt  = {key_code, 12'h000};
                  w_bcd2_nxt  = '0;
                  w_op_nxt    = 2'b00;
                  w_cnt_nxt   = 3'd1;
                  w_disp_nxt  = {key_code, 12'h000};
                  w_neg_nxt   = 1'b0;
                  w_state_nxt = S_OP1;
               end else if (w_accept && w_is_op && !r_neg) begin
                  // chain on the shown result; negative results cannot be
                  // represented as an operand, so they are not chainable
                  w_bcd1_nxt  = r_disp;
                  w_bcd2_nxt  = '0;
                  w_op_nxt    = w_op_code;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_OP2;
               end
            end
            default: w_state_nxt = S_OP1;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) r_state <= S_OP1;
      else       r_state <= w_state_nxt;
   end

   // Operand, display and counter registers.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_bcd1 <= '0;
         r_bcd2 <= '0;
         r_op   <= 2'b00;
         r_disp <= '0;
         r_neg  <= 1'b0;
         r_rv   <= 1'b0;
         r_cnt  <= '0;
         r_wait <= '0;
      end else begin
         r_bcd1 <= w_bcd1_nxt;
         r_bcd2 <= w_bcd2_nxt;
         r_op   <= w_op_nxt;
         r_disp <= w_disp_nxt;
         r_neg  <= w_neg_nxt;
         r_rv   <= w_rv_nxt;
         r_cnt  <= w_cnt_nxt;
         r_wait <= w_wait_nxt;
      end
   end

   assign bcd1         = r_bcd1;
   assign bcd2         = r_bcd2;
   assign op_selected  = r_op;
   assign display      = r_disp;
   assign display_neg  = r_neg;
   assign result_valid = r_rv;

endmodule

// File: tb/tb_calc_key_entry.sv
`timescale 1ns/1ps
// Bench for calc_key_entry: directed key sequences, a behavioural model of the
// entry rules, and a per-cycle compare of every output against that model.
module tb_calc_key_entry;

   localparam int LAT = 2;
   localparam int M_OP1 = 0, M_OP2 = 1, M_CALC = 2, M_SHOW = 3;

   logic        clk = 1'b0;
   logic        clear = 1'b1;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic [15:0] alu_result = 16'h0000;
   logic        alu_special = 1'b0;
   logic        key_ready;
   logic [15:0] bcd1, bcd2, display;
   logic [1:0]  op_selected;
   logic        display_neg, result_valid;

   int total = 0;
   int bad = 0;

   // model state
   int          m_mode = M_OP1;
   int          m_cnt = 0;
   int          m_edges = 0;
   logic [15:0] m_b1 = 16'h0, m_b2 = 16'h0, m_disp = 16'h0;
   logic [1:0]  m_op = 2'b00;
   logic        m_neg = 1'b0, m_rv = 1'b0;

   calc_key_entry #(.ALU_LAT(LAT)) dut (
      .clk(clk), .clear(clear), .key_valid(key_valid), .key_code(key_code),
      .key_ready(key_ready), .alu_result(alu_result), .alu_special(alu_special),
      .bcd1(bcd1), .bcd2(bcd2), .op_selected(op_selected), .display(display),
      .display_neg(display_neg), .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_OP1; m_cnt = 0; m_edges = 0;
      m_b1 = 16'h0; m_b2 = 16'h0; m_disp = 16'h0;
      m_op = 2'b00; m_neg = 1'b0; m_rv = 1'b0;
   endtask

   // One clock edge of the entry rules, given the inputs seen at that edge.
   task automatic model_step(input logic v, input logic [3:0] c);
      logic [15:0] dig;
      if (clear) begin
         model_reset();
         return;
      end
      m_rv = 1'b0;
      if (m_mode == M_CALC) begin
         m_edges++;
         if (m_edges == LAT) begin
            m_disp = alu_result; m_neg = alu_special; m_rv = 1'b1; m_mode = M_SHOW;
         end
         return;
      end
      if (!v) return;
      if (c == 4'hE) begin
         model_reset();
         return;
      end
      dig = {12'h000, c} << (12 - 4 * m_cnt);
      if (m_mode == M_OP1) begin
         if (c <= 4'd9 && m_cnt < 4) begin
            m_b1 = m_b1 + dig; m_disp = m_b1; m_cnt++;
         end else if ((c == 4'hA || c == 4'hB) && m_cnt > 0) begin
            m_op = (c == 4'hA) ? 2'b01 : 2'b10; m_cnt = 0; m_mode = M_OP2;
         end
      end else if (m_mode == M_OP2) begin
         if (c <= 4'd9 && m_cnt < 4) begin
            m_b2 = m_b2 + dig; m_disp = m_b2; m_cnt++;
         end else if ((c == 4'hA || c == 4'hB) && m_cnt == 0) begin
            m_op = (c == 4'hA) ? 2'b01 : 2'b10;
         end else if (c == 4'hC && m_cnt > 0) begin
            m_edges = 0; m_mode = M_CALC;
         end
      end else begin
         if (c <= 4'd9) begin
            m_b1 = {c, 12'h000}; m_b2 = 16'h0; m_op = 2'b00; m_cnt = 1;
            m_disp = m_b1; m_neg = 1'b0; m_mode = M_OP1;
         end else if ((c == 4'hA || c == 4'hB) && !m_neg) begin
            m_b1 = m_disp; m_b2 = 16'h0; m_op = (c == 4'hA) ? 2'b01 : 2'b10;
            m_cnt = 0; m_mode = M_OP2;
         end
      end
   endtask

   // Compare every output with the model once per cycle, away from the edge.
   always @(negedge clk) begin
      chk("key_ready", key_ready, (m_mode != M_CALC));
      chk("bcd1", bcd1, m_b1);
      chk("bcd2", bcd2, m_b2);
      chk("op_selected", op_selected, m_op);
      chk("display", display, m_disp);
      chk("display_neg", display_neg, m_neg);
      chk("result_valid", result_valid, m_rv);
   end

   task automatic tick(input logic v, input logic [3:0] c);
      key_valid = v;
      key_code  = c;
      @(posedge clk);
      model_step(v, c);
      @(negedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] c);
      tick(1'b1, c);
   endtask

   // Press '=' with the ALU stub showing val, then watch for the result pulse.
   task automatic eval_c(input logic [15:0] val, input logic sp);
      int pulses, pos;
      alu_result  = val;
      alu_special = sp;
      press(4'hC);
      pulses = 0;
      pos = 0;
      for (int i = 1; i <= LAT + 2; i++) begin
         tick(1'b0, 4'h0);
         if (result_valid === 1'b1) begin
            pulses++;
            if (pos == 0) pos = i;
         end
      end
      chk("rv_pulses", pulses, 1);
      chk("rv_edge", pos, LAT);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      tick(1'b0, 4'h0);
      tick(1'b0, 4'h0);
      chk("rst_bcd1", bcd1, 16'h0);
      chk("rst_op", op_selected, 2'b00);
      chk("rst_rv", result_valid, 1'b0);
      clear = 1'b0;
      tick(1'b0, 4'h0);
      chk("rst_ready", key_ready, 1'b1);

      // 12 + 34
      press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4);
      eval_c(16'h4600, 1'b0);
      chk("t1_bcd1", bcd1, 16'h1200);
      chk("t1_bcd2", bcd2, 16'h3400);
      chk("t1_op", op_selected, 2'b01);
      chk("t1_disp", display, 16'h4600);
      chk("t1_neg", display_neg, 1'b0);

      // chain: result + 1
      press(4'hA); press(4'h1);
      eval_c(16'h5600, 1'b0);
      chk("chain_bcd1", bcd1, 16'h4600);
      chk("chain_bcd2", bcd2, 16'h1000);
      chk("chain_op", op_selected, 2'b01);
      chk("chain_disp", display, 16'h5600);

      // 15 - 25, negative result
      press(4'hE);
      chk("e_bcd1", bcd1, 16'h0);
      press(4'h1); press(4'h5); press(4'hB); press(4'h2); press(4'h5);
      eval_c(16'h1000, 1'b1);
      chk("t2_op", op_selected, 2'b10);
      chk("t2_disp", display, 16'h1000);
      chk("t2_neg", display_neg, 1'b1);
      press(4'hA);
      chk("t2_noch_op", op_selected, 2'b10);
      chk("t2_noch_bcd1", bcd1, 16'h1500);
      chk("t2_noch_disp", display, 16'h1000);
      press(4'hC);
      chk("t2_noeq_rv", result_valid, 1'b0);
      press(4'h9);
      chk("show_dig_bcd1", bcd1, 16'h9000);
      chk("show_dig_bcd2", bcd2, 16'h0);
      chk("show_dig_op", op_selected, 2'b00);
      chk("show_dig_neg", display_neg, 1'b0);

      // five digits, the fifth is dropped
      press(4'hE);
      press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'h5);
      chk("t3_bcd1", bcd1, 16'h9876);
      chk("t3_disp", display, 16'h9876);

      // operator replaced before operand 2
      press(4'hE);
      press(4'h4); press(4'hA); press(4'hB); press(4'h2);
      eval_c(16'h2000, 1'b0);
      chk("t4_op", op_selected, 2'b10);
      chk("t4_bcd2", bcd2, 16'h2000);
      chk("t4_bcd1", bcd1, 16'h4000);

      // C, A and unused codes ignored with no digits yet
      press(4'hE);
      press(4'hC); press(4'hA); press(4'hD); press(4'hF);
      chk("t5_op", op_selected, 2'b00);
      chk("t5_ready", key_ready, 1'b1);
      press(4'h3);
      chk("t5_bcd1", bcd1, 16'h3000);
      press(4'hB);
      chk("t5_op_b", op_selected, 2'b10);

      // keys blocked during CALC, then an asynchronous abort
      press(4'hE);
      press(4'h1); press(4'hA); press(4'h2);
      alu_result = 16'h0042;
      press(4'hC);
      chk("calc_ready", key_ready, 1'b0);
      tick(1'b1, 4'h7);
      chk("calc_bcd2", bcd2, 16'h2000);
      chk("calc_ready2", key_ready, 1'b0);
      key_valid = 1'b0;
      clear = 1'b1;
      #1;
      model_reset();
      chk("abort_bcd1", bcd1, 16'h0);
      chk("abort_bcd2", bcd2, 16'h0);
      chk("abort_op", op_selected, 2'b00);
      chk("abort_disp", display, 16'h0);
      chk("abort_ready", key_ready, 1'b1);
      tick(1'b0, 4'h0);
      clear = 1'b0;
      pulses = 0;
      for (int i = 0; i < LAT + 2; i++) begin
         tick(1'b0, 4'h0);
         if (result_valid === 1'b1) pulses++;
      end
      chk("abort_no_rv", pulses, 0);

      key_valid = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
